// File: rtl/addr_cal_read_phase2.sv
// Phase-2 read address generator for merge trees 00 and 08.
// Picks the four source channels (the parity set opposite to the phase-2
// writer), then issues chunked read requests round-robin across them so that
// every merge-tree leaf is fed concurrently.
// Reports completion once every issued request has been acknowledged by a
// read-done pulse.
//
// Request handshake: a request is transferred in a cycle where
// o_read_req_valid=1 and i_read_req_ready=1. While valid is high and ready is
// low, addr/size/ch are held stable. Valid is never withdrawn before the
// transfer completes.

// Per-channel base address. Channel regions are laid out back to back from
// the channel-0 pointer, each region holding one channel's share of the
// transfer (a quarter of the total byte count). One cycle of registered
// latency.
module dsp_ch_addr #(
   parameter int AW     = 64,
   parameter int SW     = 64,
   parameter int CH_IDX = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] i_ptr_ch_0,
   input  logic [SW-1:0] i_xfer_size_in_bytes,
   output logic [AW-1:0] o_ch_addr
);

   logic [SW-1:0] per_ch_w;
   logic [AW-1:0] stride_w;
   logic [AW-1:0] addr_q;

   assign per_ch_w  = i_xfer_size_in_bytes >> 2;
   assign stride_w  = AW'(per_ch_w);
   assign o_ch_addr = addr_q;

   // Register the channel base so downstream sees a clean, settled value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= i_ptr_ch_0 + stride_w * AW'(CH_IDX);
      end
   end

endmodule

module addr_cal_read_phase2 #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_XFER_SIZE_WIDTH  = 64,
   parameter int CHANNEL_OFFSET     = 0,
   parameter int C_CHUNK_BYTES      = 4096
) (
   input  logic                          aclk,
   input  logic                          areset_n,
   input  logic                          i_start,
   input  logic                          i_pass_parity,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_ptr_ch_0,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  i_xfer_size_in_bytes,
   output logic                          o_read_req_valid,
   input  logic                          i_read_req_ready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] o_read_addr,
   output logic [C_XFER_SIZE_WIDTH-1:0]  o_read_size,
   output logic [1:0]                    o_read_ch,
   input  logic                          i_read_done,
   output logic                          o_phase_2_read_done
);

   localparam int AW         = C_M_AXI_ADDR_WIDTH;
   localparam int SW         = C_XFER_SIZE_WIDTH;
   localparam int CHUNK_LOG2 = $clog2(C_CHUNK_BYTES);
   localparam logic [SW-1:0] CHUNK_SW   = SW'(C_CHUNK_BYTES);
   localparam logic [SW-1:0] CHUNK_MASK = SW'(C_CHUNK_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   state_e state_q, state_d;

   logic          parity_q,   parity_d;
   logic [SW-1:0] s_q,        s_d;
   logic [SW-1:0] n_q,        n_d;
   logic [SW-1:0] last_q,     last_d;
   logic [SW-1:0] k_q,        k_d;
   logic [1:0]    i_q,        i_d;
   logic [SW-1:0] issued_q,   issued_d;
   logic [SW-1:0] done_cnt_q, done_cnt_d;
   logic          valid_q,    valid_d;
   logic [AW-1:0] addr_q,     addr_d;
   logic [SW-1:0] size_q,     size_d;
   logic [1:0]    ch_q,       ch_d;
   logic          done_q;

   // ---------------------------------------------------------------------
   // Channel base addresses and source selection
   // ---------------------------------------------------------------------
   logic [AW-1:0] ch_addr_w [8];
   logic [AW-1:0] src_w     [4];

   for (genvar g = 0; g < 8; g++) begin : g_ch_addr
      dsp_ch_addr #(
         .AW     (AW),
         .SW     (SW),
         .CH_IDX (CHANNEL_OFFSET + g)
      ) u_ch_addr (
         .clk                  (aclk),
         .rst_n                (areset_n),
         .i_ptr_ch_0           (i_ptr_ch_0),
         .i_xfer_size_in_bytes (i_xfer_size_in_bytes),
         .o_ch_addr            (ch_addr_w[g])
      );
   end

   // Odd parity reads the odd channels, even parity the even ones; the
   // phase-2 writer uses the other set.
   for (genvar s = 0; s < 4; s++) begin : g_src
      assign src_w[s] = parity_q ? ch_addr_w[2*s+1] : ch_addr_w[2*s];
   end

   // ---------------------------------------------------------------------
   // Chunk arithmetic
   // ---------------------------------------------------------------------
   logic [SW-1:0] rem_w;
   logic [SW-1:0] n_calc_w;
   logic [SW-1:0] last_calc_w;
   logic [SW-1:0] total_w;
   logic          final_req_w;
   logic          handshake_w;
   logic          done_counted_w;
   logic [SW-1:0] done_cnt_inc_w;
   logic [1:0]    i_nx_w;
   logic [SW-1:0] k_nx_w;
   logic [AW-1:0] offset_nx_w;

   assign rem_w       = s_q & CHUNK_MASK;
   assign n_calc_w    = (s_q >> CHUNK_LOG2) + ((rem_w != '0) ? SW'(1) : SW'(0));
   assign last_calc_w = (rem_w == '0) ? CHUNK_SW : rem_w;
   assign total_w     = n_q << 2;
   assign final_req_w = (issued_q == total_w - SW'(1));
   assign handshake_w = valid_q && i_read_req_ready;

   // Completion pulses only count once requests can be in flight.
   assign done_counted_w = i_read_done &&
                           ((state_q == ST_ISSUE) || (state_q == ST_DRAIN) ||
                            (state_q == ST_DONE));
   assign done_cnt_inc_w = done_cnt_q + (done_counted_w ? SW'(1) : SW'(0));

   // Next position in the chunk-major, channel-minor issue order.
   assign i_nx_w      = i_q + 2'd1;
   assign k_nx_w      = (i_q == 2'd3) ? k_q + SW'(1) : k_q;
   assign offset_nx_w = AW'(k_nx_w) << CHUNK_LOG2;

   // ---------------------------------------------------------------------
   // FSM next state and datapath next values
   // ---------------------------------------------------------------------
   // Default is to hold everything; each state overrides what it changes.
   always_comb begin
      state_d    = state_q;
      parity_d   = parity_q;
      s_d        = s_q;
      n_d        = n_q;
      last_d     = last_q;
      k_d        = k_q;
      i_d        = i_q;
      issued_d   = issued_q;
      done_cnt_d = done_cnt_inc_w;
      valid_d    = valid_q;
      addr_d     = addr_q;
      size_d     = size_q;
      ch_d       = ch_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               parity_d   = i_pass_parity;
               s_d        = i_xfer_size_in_bytes >> 2;
               k_d        = '0;
               i_d        = '0;
               issued_d   = '0;
               done_cnt_d = '0;
               state_d    = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // Channel bases have settled; size up the job and stage the
            // first request (chunk 0, channel 0).
            n_d    = n_calc_w;
            last_d = last_calc_w;
            if (s_q == '0) begin
               state_d = ST_DONE;
            end else begin
               valid_d = 1'b1;
               addr_d  = src_w[0];
               size_d  = (n_calc_w == SW'(1)) ? last_calc_w : CHUNK_SW;
               ch_d    = 2'd0;
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (handshake_w) begin
               issued_d = issued_q + SW'(1);
               if (final_req_w) begin
                  valid_d = 1'b0;
                  addr_d  = '0;
                  size_d  = '0;
                  ch_d    = 2'd0;
                  state_d = (done_cnt_inc_w == total_w) ? ST_DONE : ST_DRAIN;
               end else begin
                  i_d    = i_nx_w;
                  k_d    = k_nx_w;
                  addr_d = src_w[i_nx_w] + offset_nx_w;
                  size_d = (k_nx_w == n_q - SW'(1)) ? last_q : CHUNK_SW;
                  ch_d   = i_nx_w;
               end
            end
         end

         ST_DRAIN: begin
            if (done_cnt_inc_w == total_w) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, latched job parameters and registered request outputs.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         parity_q   <= 1'b0;
         s_q        <= '0;
         n_q        <= '0;
         last_q     <= '0;
         k_q        <= '0;
         i_q        <= '0;
         issued_q   <= '0;
         done_cnt_q <= '0;
         valid_q    <= 1'b0;
         addr_q     <= '0;
         size_q     <= '0;
         ch_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         parity_q   <= parity_d;
         s_q        <= s_d;
         n_q        <= n_d;
         last_q     <= last_d;
         k_q        <= k_d;
         i_q        <= i_d;
         issued_q   <= issued_d;
         done_cnt_q <= done_cnt_d;
         valid_q    <= valid_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         ch_q       <= ch_d;
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign o_read_req_valid    = valid_q;
   assign o_read_addr         = addr_q;
   assign o_read_size         = size_q;
   assign o_read_ch           = ch_q;
   assign o_phase_2_read_done = done_q;

endmodule

// File: doc/addr_cal_read_phase2.md
# addr_cal_read_phase2

Phase-2 read address generator for merge trees 00 and 08. It is the read-side counterpart of the phase-2 write address calculator. On start it selects the four source channels, which are the opposite parity set to the phase-2 write targets. It then issues chunked read requests to the AXI read master, interleaving chunks round-robin across the four channels so each merge-tree leaf receives data concurrently. It reports phase-2 read completion once every issued request has completed.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width
- C_XFER_SIZE_WIDTH, 64, byte-count width
- CHANNEL_OFFSET, 0, first channel index passed to dsp_ch_addr
- C_CHUNK_BYTES, 4096, maximum bytes per read request; power of two, ≥64

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset; asynchronous, active-low
- i_start  in  1  phase-2 start pulse
- i_pass_parity  in  1  parity of the phase-1 pass count
- i_ptr_ch_0  in  C_M_AXI_ADDR_WIDTH  channel-0 base address; stable from ≥2 cycles before i_start until done
- i_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  total input bytes across the 4 source channels
- o_read_req_valid  out  1  read request valid
- i_read_req_ready  in  1  read master accepts the request
- o_read_addr  out  C_M_AXI_ADDR_WIDTH  request byte address
- o_read_size  out  C_XFER_SIZE_WIDTH  request byte count
- o_read_ch  out  2  source channel index 0-3, used for leaf routing
- i_read_done  in  1  one-cycle pulse per completed request
- o_phase_2_read_done  out  1  one-cycle completion pulse

## Operation
- Base addresses: eight dsp_ch_addr instances, channel ch uses CHANNEL_OFFSET+ch, giving A[0..7]. Each has 1-cycle registered latency.
- Source channel i (0-3): A[2i+1] when i_pass_parity=1, A[2i] when i_pass_parity=0. This is the opposite set from the phase-2 writer.
- On i_start the block latches i_pass_parity and computes S = i_xfer_size_in_bytes >> 2, the bytes per source channel.
- Chunk count per channel: N = ceil(S / C_CHUNK_BYTES). Last-chunk size L = S − (N−1)·C_CHUNK_BYTES.
- Issue order: k = 0..N−1 outer loop, i = 0..3 inner loop. Each request carries:
  - addr = src[i] + k·C_CHUNK_BYTES
  - size = C_CHUNK_BYTES, or L when k = N−1
  - ch = i
- Counters: chunk index k, channel index i, issued count, done count. Count width is C_XFER_SIZE_WIDTH.
- FSM states:
  - IDLE: i_start → LOAD.
  - LOAD: one cycle to let A[] settle; S and N are computed here. S=0 → DONE; otherwise → ISSUE.
  - ISSUE: holds valid. On the final handshake (k=N−1, i=3) → DRAIN.
  - DRAIN: waits until done count equals 4N → DONE.
  - DONE: pulses o_phase_2_read_done → IDLE.
- i_start is ignored outside IDLE.
- i_read_done is ignored in IDLE and LOAD.
- A simultaneous handshake and i_read_done in the same cycle both count.
- Addition is modulo 2^C_M_AXI_ADDR_WIDTH; wrap is not checked.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0. An areset_n assertion mid-operation aborts immediately and discards outstanding-request state.
- o_read_req_valid, o_read_addr, o_read_size and o_read_ch are registered outputs.
- First request: i_start sampled in cycle t → LOAD in t+1 → valid high in t+2.
- Request hold: valid, addr, size and ch stay stable while valid=1 and ready=0.
- Handshake occurs in a cycle where valid=1 and ready=1. The next request is presented in the following cycle with valid still high, giving a throughput of one request per cycle.
- Valid deasserts in the cycle after the final handshake.
- Completion pulse: o_phase_2_read_done is high for exactly one cycle, one cycle after the cycle in which done count reaches 4N. This also covers i_read_done arriving in the same cycle as the final handshake.
- S=0: no requests are issued; o_phase_2_read_done pulses at t+2.

## Test plan
- Even-parity interleave: parity=0, size=32768, chunk=4096 → S=8192, 8 requests:
  - (A[0],4096,ch0), (A[2],4096,ch1), (A[4],4096,ch2), (A[6],4096,ch3)
  - then A[0]+4096, A[2]+4096, A[4]+4096, A[6]+4096 in the same channel order
  - ready tied 1 → valid stays high for 8 consecutive cycles from t+2
  - done pulse one cycle after the 8th i_read_done
- Odd parity, partial chunk: parity=1, size=20000 → S=5000, sources A[1],A[3],A[5],A[7]:
  - 8 requests: 4 of size 4096 at offset 0, then 4 of size 904 at offset 4096
- Backpressure: random ready at 30% → addr, size and ch never change while valid=1 and ready=0; request order identical to the first scenario.
- Zero size: size=0 → valid never asserts; done pulses exactly at t+2; a second i_start afterwards repeats the same behaviour.
- Out-of-order completion timing: i_read_done pulses delayed 0-20 cycles, with one pulse coincident with the final handshake → exactly one done pulse, only after the 8th done is sampled. A spurious i_read_done in IDLE is ignored.
- Reset mid-ISSUE: areset_n low after the 3rd handshake → all outputs 0 within the reset; after release, a fresh i_start with the first scenario's stimulus reproduces that scenario's full sequence.
